usb_ls_hid_responder: RTL and testbench
=======================================

# usb_ls_hid_responder

Device-side packet engine for a low-speed USB HID function: the responder counterpart of `usbh_host_hid`. It decodes IN tokens delivered byte-wise by a USB PHY receiver and answers on one interrupt endpoint. If a report is pending it sends it as DATA0/DATA1 with CRC16; otherwise it sends NAK. It tracks the host ACK to advance the data toggle. The block sits between the PHY byte interface and the report source (e.g. a keyboard scanner); enumeration/control traffic is out of scope.

## Interface
- `C_report_length`, 8, report size in bytes (1..64)
- `C_endpoint`, 1, interrupt IN endpoint number (4 bits)
- `C_ack_timeout`, 64, clocks to wait for host handshake after DATA end
- `clk`  in  1  single clock, 6 MHz for low-speed (4 clocks per bit)
- `reset`  in  1  synchronous, active-high
- `dev_addr`  in  7  assigned device address, sampled at token decode
- `report`  in  C_report_length*8  report bytes, byte 0 = bits [7:0], sent first
- `report_valid`  in  1  load strobe; accepted only when `report_ready`=1
- `report_ready`  out  1  shadow buffer may be overwritten
- `rx_data`  in  8  received byte
- `rx_strobe`  in  1  `rx_data` valid this clock
- `rx_active`  in  1  packet in progress; falling edge = EOP
- `rx_error`  in  1  bit-stuff/PHY error in current packet
- `tx_data`  out  8  byte to transmit
- `tx_valid`  out  1  packet in progress, byte offered
- `tx_ready`  in  1  PHY consumes `tx_data` this clock
- `toggle`  out  1  data toggle for next DATA packet (0=DATA0)
- `sent`  out  1  one-clock pulse when a report is ACKed

## Operation
- Report shadow: `report_valid`&`report_ready` copies `report` into shadow, sets `pending`. Strobe while `report_ready`=0 is ignored. `report_ready`=0 only in TX_DATA and WAIT_ACK.
- PID check: byte valid iff low nibble == ~high nibble. Codes used: IN 0x69, DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A.
- States:
  - IDLE: on the first `rx_strobe` of a packet → TOKEN.
  - TOKEN: collect bytes. At `rx_active` fall, decode. The packet is a match when all hold: exactly 3 bytes, PID=IN, addr=`dev_addr`, endp=`C_endpoint`, no `rx_error`, and CRC5 passes when enabled. Addr is byte1[6:0]; endp is {byte2[2:0],byte1[7]}. On a match → TX_DATA if `pending`, else TX_HS. Otherwise → IDLE with no transmission.
  - DISCARD: non-IN or malformed packets are ignored until `rx_active`=0, then → IDLE.
  - TX_HS: send single byte 0x5A, → IDLE.
  - TX_DATA: send PID (toggle ? 0x4B : 0xC3), then C_report_length shadow bytes, then CRC16 low byte, then high byte. → WAIT_ACK.
  - WAIT_ACK: counter from 0. A 1-byte packet 0xD2 without `rx_error` means ACK: flip `toggle`, clear `pending`, pulse `sent`, → IDLE. Any other packet, or counter reaching C_ack_timeout, → IDLE with `toggle` and `pending` unchanged, so a retry resends identical data.
- CRC16 rules:
  - poly 0x8005, init 0xFFFF, bytes processed LSB-first, result inverted and bit-reversed as per USB.
  - Covers data bytes only.
- Receive input is ignored while `tx_valid`=1.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `report_ready`=1, `toggle`=0, `sent`=0; pending cleared; state IDLE.
- Turnaround: `tx_valid` rises exactly 2 clocks after the clock where `rx_active` is first sampled 0 for a matching IN token.
- Byte handshake:
  - Byte transfers on `tx_valid`&`tx_ready`.
  - `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0.
  - Next byte appears the clock after acceptance.
  - `tx_valid` falls the clock after the last byte is accepted; there is no gap inside a packet once `tx_ready` is high.
- WAIT_ACK counter starts the clock `tx_valid` falls.
- `sent` is asserted the clock after the ACK packet's `rx_active` falls. `report_ready` returns to 1 in that same clock.
- Reset mid-packet: `tx_valid`=0 next clock, partial packet abandoned, shadow contents invalid.

## Configuration
- `USB_LS_HID_CRC5_CHECK_EN` defined: token CRC5 is checked (poly 0x05, init 0x1F, over 11 addr/endp bits, residual 0x0C). A failing token is ignored, with no reply.
- Undefined: CRC5 bits are ignored; match uses PID/addr/endp only (smaller area).

## Test plan
- `dev_addr`=5, no pending, IN token 0x69 to addr 5 / ep 1 → single byte 0x5A. `toggle` stays 0.
- Load report 00..07, IN → C3,00,01,…,07,CRC lo,CRC hi matching the CRC16 model. Then ACK 0xD2 → `sent` pulse, `toggle`=1. Next load+IN → PID 0x4B.
- C_report_length=9, report "123456789" (0x31..0x39) → CRC bytes 0xC8 then 0xB4.
- DATA sent with no ACK for C_ack_timeout clocks → next IN resends identical packet with the same PID. `report_valid` during WAIT_ACK is ignored.
- IN to addr 6, to ep 2, 4-byte token, or with `rx_error` → `tx_valid` stays 0. With macro, a corrupted CRC5 → no reply; without macro → reply.
- `tx_ready` held low 10 clocks mid-packet → `tx_data` stable. Assert `reset` mid-DATA → `tx_valid`=0 next clock, `toggle`=0, next IN → NAK.

Source files
------------

// File: rtl/usb_ls_hid_responder.sv
// usb_ls_hid_responder: device-side packet engine for one low-speed HID
// interrupt IN endpoint. It decodes IN tokens from the PHY byte stream and
// answers with the pending report (DATA0/DATA1 + CRC16) or with NAK. The data
// toggle advances only on a host ACK.
// Optional feature macro: USB_LS_HID_CRC5_CHECK_EN enables the token CRC5 check.
module usb_ls_hid_responder #(
  parameter int C_report_length = 8,
  parameter int C_endpoint      = 1,
  parameter int C_ack_timeout   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [6:0]                   dev_addr,
  input  logic [C_report_length*8-1:0] report,
  input  logic                         report_valid,
  output logic                         report_ready,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_strobe,
  input  logic                         rx_active,
  input  logic                         rx_error,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         toggle,
  output logic                         sent
);

  localparam int LEN   = C_report_length;
  localparam int IDX_W = $clog2(C_report_length + 3);
  localparam int CNT_W = $clog2(C_ack_timeout + 1);

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DISCARD, S_TURN, S_TX_HS, S_TX_DATA, S_WAIT_ACK
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         shadow_reg [0:LEN-1];
  logic               pending_reg, toggle_reg, sent_reg;
  logic [7:0]         tok0_reg, tok1_reg, tok2_reg;
  logic [2:0]         rx_cnt_reg;
  logic               rx_err_reg;
  logic               turn_cnt_reg, turn_data_reg;
  logic [IDX_W-1:0]   tx_idx_reg;
  logic [15:0]        crc_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic               ack_busy_reg;

  logic rx_byte, tx_fire, tx_last, token_match, ack_now, crc5_ok, load;
  logic [7:0] tx_byte;

  // USB CRC16 in reflected form (0x8005 reversed = 0xA001), data LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

`ifdef USB_LS_HID_CRC5_CHECK_EN
  // Runs the 11 addr/endp bits plus the 5 CRC bits through the generator;
  // an intact token always leaves the residual 0x0C.
  function automatic logic crc5_residual_ok(input logic [15:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      fb = bits[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    return c == 5'h0C;
  endfunction
  assign crc5_ok = crc5_residual_ok({tok2_reg, tok1_reg});
`else
  assign crc5_ok = 1'b1;
  logic unused_crc5_bits;
  assign unused_crc5_bits = ^tok2_reg[7:3];
`endif

  assign tx_valid     = (state_reg == S_TX_HS) || (state_reg == S_TX_DATA);
  assign report_ready = (state_reg != S_TX_DATA) && (state_reg != S_WAIT_ACK);
  assign tx_fire      = tx_valid && tx_ready;
  assign tx_last      = (tx_idx_reg == IDX_W'(LEN + 2));
  assign rx_byte      = rx_strobe && !tx_valid;
  assign load         = report_valid && report_ready;
  assign toggle       = toggle_reg;
  assign sent         = sent_reg;
  assign tx_data      = tx_byte;

  assign token_match = (rx_cnt_reg == 3'd3) && (tok0_reg == PID_IN) &&
                       (tok1_reg[6:0] == dev_addr) &&
                       ({tok2_reg[2:0], tok1_reg[7]} == 4'(C_endpoint)) &&
                       !rx_err_reg && !rx_error && crc5_ok;

  // Next-state logic and the ACK decision.
  always_comb begin
    state_next = state_reg;
    ack_now    = 1'b0;
    case (state_reg)
      S_IDLE:    if (rx_byte) state_next = (rx_data == PID_IN) ? S_TOKEN : S_DISCARD;
      S_TOKEN:   if (!rx_active) state_next = token_match ? S_TURN : S_IDLE;
      S_DISCARD: if (!rx_active) state_next = S_IDLE;
      S_TURN:    if (turn_cnt_reg) state_next = turn_data_reg ? S_TX_DATA : S_TX_HS;
      S_TX_HS:   if (tx_fire) state_next = S_IDLE;
      S_TX_DATA: if (tx_fire && tx_last) state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_busy_reg) begin
          if (!rx_active) begin
            state_next = S_IDLE;
            ack_now = (rx_cnt_reg == 3'd1) && (tok0_reg == PID_ACK) && !rx_err_reg && !rx_error;
          end
        end else if (!rx_byte && wait_cnt_reg == CNT_W'(C_ack_timeout)) begin
          state_next = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Byte offered to the PHY: handshake, PID, report bytes, inverted CRC16.
  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      S_TX_HS: tx_byte = PID_NAK;
      S_TX_DATA: begin
        if (tx_idx_reg == '0)                       tx_byte = toggle_reg ? PID_DATA1 : PID_DATA0;
        else if (tx_idx_reg == IDX_W'(LEN + 1))     tx_byte = ~crc_reg[7:0];
        else if (tx_idx_reg == IDX_W'(LEN + 2))     tx_byte = ~crc_reg[15:8];
        else begin
          for (int i = 0; i < LEN; i++)
            if (tx_idx_reg == IDX_W'(i + 1)) tx_byte = shadow_reg[i];
        end
      end
      default: tx_byte = 8'h00;
    endcase
  end

  // Report shadow: one byte lane per generate iteration.
  for (genvar gi = 0; gi < LEN; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (reset)     shadow_reg[gi] <= 8'h00;
      else if (load) shadow_reg[gi] <= report[gi*8 +: 8];
    end
  end

  // State register plus token/ACK capture, transmit index, CRC and toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      pending_reg   <= 1'b0;
      toggle_reg    <= 1'b0;
      sent_reg      <= 1'b0;
      tok0_reg      <= 8'h00;
      tok1_reg      <= 8'h00;
      tok2_reg      <= 8'h00;
      rx_cnt_reg    <= 3'd0;
      rx_err_reg    <= 1'b0;
      turn_cnt_reg  <= 1'b0;
      turn_data_reg <= 1'b0;
      tx_idx_reg    <= '0;
      crc_reg       <= 16'hFFFF;
      wait_cnt_reg  <= '0;
      ack_busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sent_reg  <= 1'b0;
      if (load) pending_reg <= 1'b1;
      case (state_reg)
        S_IDLE: if (rx_byte) begin
          tok0_reg   <= rx_data;
          rx_cnt_reg <= 3'd1;
          rx_err_reg <= rx_error;
        end
        S_TOKEN: begin
          rx_err_reg <= rx_err_reg | rx_error;
          if (rx_byte) begin
            if (rx_cnt_reg == 3'd1) tok1_reg <= rx_data;
            if (rx_cnt_reg == 3'd2) tok2_reg <= rx_data;
            if (rx_cnt_reg != 3'd7) rx_cnt_reg <= rx_cnt_reg + 3'd1;
          end
          if (!rx_active) begin
            turn_cnt_reg  <= 1'b0;
            turn_data_reg <= pending_reg;
            tx_idx_reg    <= '0;
            crc_reg       <= 16'hFFFF;
          end
        end
        S_TURN: turn_cnt_reg <= 1'b1;
        S_TX_DATA: if (tx_fire) begin
          tx_idx_reg <= tx_idx_reg + IDX_W'(1);
          if (tx_idx_reg != '0 && tx_idx_reg <= IDX_W'(LEN))
            crc_reg <= crc16_byte(crc_reg, tx_byte);
          if (tx_last) begin
            wait_cnt_reg <= '0;
            ack_busy_reg <= 1'b0;
            rx_cnt_reg   <= 3'd0;
            rx_err_reg   <= 1'b0;
          end
        end
        S_WAIT_ACK: begin
          rx_err_reg <= rx_err_reg | rx_error;
          if (!ack_busy_reg && wait_cnt_reg != CNT_W'(C_ack_timeout))
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          if (rx_byte) begin
            ack_busy_reg <= 1'b1;
            if (rx_cnt_reg == 3'd0) tok0_reg <= rx_data;
            if (rx_cnt_reg != 3'd7) rx_cnt_reg <= rx_cnt_reg + 3'd1;
          end
          if (ack_now) begin
            toggle_reg  <= ~toggle_reg;
            pending_reg <= 1'b0;
            sent_reg    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ls_hid_responder.sv
// Directed self-checking bench for usb_ls_hid_responder (9-byte report,
// endpoint 1, device address 5). Honors USB_LS_HID_CRC5_CHECK_EN when defined.
module tb_usb_ls_hid_responder;

  localparam int LEN = 9;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [6:0]     dev_addr = 7'd5;
  logic [LEN*8-1:0] report = '0;
  logic           report_valid = 1'b0;
  logic           report_ready;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_strobe = 1'b0;
  logic           rx_active = 1'b0;
  logic           rx_error = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           toggle;
  logic           sent;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_buf [0:15];
  logic [7:0] exp_buf [0:15];
  int         cap_n, cap_lat;
  logic       cap_stable;

  usb_ls_hid_responder #(
    .C_report_length(LEN), .C_endpoint(1), .C_ack_timeout(64)
  ) dut (
    .clk(clk), .reset(reset), .dev_addr(dev_addr), .report(report),
    .report_valid(report_valid), .report_ready(report_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_active(rx_active),
    .rx_error(rx_error), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .toggle(toggle), .sent(sent)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Token bytes {byte2, byte1, PID} for an IN token; bad flips one CRC5 bit.
  function automatic logic [31:0] make_tok(input logic [6:0] a, input logic [3:0] e, input logic bad);
    logic [10:0] d;
    logic [4:0]  c, f;
    logic        fb;
    d = {e, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    c = ~c;
    f = {c[0], c[1], c[2], c[3], c[4]};
    if (bad) f = f ^ 5'h01;
    return {8'h00, f, e[3:1], e[0], a, 8'h69};
  endfunction

  function automatic logic [15:0] crc16_model(input logic [LEN*8-1:0] r);
    logic [15:0] c;
    logic [7:0]  d;
    c = 16'hFFFF;
    for (int b = 0; b < LEN; b++) begin
      d = r[b*8 +: 8];
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send_pkt(input logic [31:0] bytes, input int nbytes, input logic err);
    @(posedge clk); #1 rx_active = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      repeat (3) @(posedge clk);
      #1 rx_data = bytes[i*8 +: 8]; rx_strobe = 1'b1; rx_error = err && (i == nbytes - 1);
      @(posedge clk); #1 rx_strobe = 1'b0; rx_error = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rx_active = 1'b0;
  endtask

  // Collects one transmitted packet; stalls tx_ready for 10 clocks at byte stall_at.
  task automatic capture(input int stall_at, input int limit);
    int stall;
    logic [7:0] held;
    logic started;
    cap_n = 0; cap_lat = -1; cap_stable = 1'b1; stall = 0; started = 1'b0; held = 8'h00;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (!tx_valid) begin
        if (started) break;
        continue;
      end
      if (!started) begin started = 1'b1; cap_lat = c; end
      if (cap_n == stall_at && stall < 10) begin
        if (stall == 0) held = tx_data;
        else if (tx_data !== held) cap_stable = 1'b0;
        tx_ready = 1'b0;
        stall++;
      end else begin
        tx_ready = 1'b1;
        if (cap_n < 16) cap_buf[cap_n] = tx_data;
        cap_n++;
      end
    end
    tx_ready = 1'b1;
    $display("packet: %0d bytes transmitted, turnaround %0d", cap_n, cap_lat);
  endtask

  task automatic load_report(input logic [LEN*8-1:0] r);
    @(posedge clk); #1 report = r; report_valid = 1'b1;
    @(posedge clk); #1 report_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (report_ready !== 1'b1) begin n_fail++; $display("FAIL reset_report_ready: got %b expected 1", report_ready); end
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL reset_toggle: got %b expected 0", toggle); end
    n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL reset_sent: got %b expected 0", sent); end
  endtask

  task automatic test_nak;
    send_pkt(make_tok(7'd5, 4'd1, 1'b0), 3, 1'b0);
    capture(99, 300);
    n_checks++; if (cap_lat !== 3) begin n_fail++; $display("FAIL nak_turnaround: got %0d expected 3", cap_lat); end
    n_checks++; if (cap_n !== 1) begin n_fail++; $display("FAIL nak_len: got %0d expected 1", cap_n); end
    n_checks++; if (cap_buf[0] !== 8'h5A) begin n_fail++; $display("FAIL nak_pid: got %h expected 5a", cap_buf[0]); end
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL nak_toggle: got %b expected 0", toggle); end
  endtask

  task automatic test_data_ack;
    load_report(72'h39_38_37_36_35_34_33_32_31);
    exp_buf[0] = 8'hC3;
    for (int i = 0; i < 9; i++) exp_buf[i+1] = 8'h31 + 8'(i);
    exp_buf[10] = 8'hC8; exp_buf[11] = 8'hB4;
    send_pkt(make_tok(7'd5, 4'd1, 1'b0), 3, 1'b0);
    capture(99, 300);
    n_checks++; if (cap_lat !== 3) begin n_fail++; $display("FAIL data_turnaround: got %0d expected 3", cap_lat); end
    n_checks++; if (cap_n !== 12) begin n_fail++; $display("FAIL data_len: got %0d expected 12", cap_n); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (cap_buf[i] !== exp_buf[i]) begin n_fail++; $display("FAIL data_byte%0d: got %h expected %h", i, cap_buf[i], exp_buf[i]); end
    end
    n_checks++; if (report_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready: got %b expected 0", report_ready); end
    send_pkt(32'h0000_00D2, 1, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (sent !== 1'b1) begin n_fail++; $display("FAIL ack_sent: got %b expected 1", sent); end
    n_checks++; if (report_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready: got %b expected 1", report_ready); end
    n_checks++; if (toggle !== 1'b1) begin n_fail++; $display("FAIL ack_toggle: got %b expected 1", toggle); end
    @(posedge clk); #1;
    n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL sent_pulse_width: got %b expected 0", sent); end
  endtask

  task automatic test_timeout_retry;
    logic [LEN*8-1:0] r;
    logic [15:0] crc;
    r = 72'h08_07_06_05_04_03_02_01_00;
    crc = crc16_model(r);
    exp_buf[0] = 8'h4B;
    for (int i = 0; i < 9; i++) exp_buf[i+1] = 8'(i);
    exp_buf[10] = crc[7:0]; exp_buf[11] = crc[15:8];
    load_report(r);
    for (int pass = 0; pass < 2; pass++) begin
      send_pkt(make_tok(7'd5, 4'd1, 1'b0), 3, 1'b0);
      capture(pass == 0 ? 99 : 3, 300);
      n_checks++; if (cap_n !== 12) begin n_fail++; $display("FAIL retry%0d_len: got %0d expected 12", pass, cap_n); end
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (cap_buf[i] !== exp_buf[i]) begin n_fail++; $display("FAIL retry%0d_byte%0d: got %h expected %h", pass, i, cap_buf[i], exp_buf[i]); end
      end
      if (pass == 1) begin
        n_checks++; if (cap_stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b expected 1", cap_stable); end
      end
      load_report({LEN{8'hFF}});
      repeat (80) @(posedge clk);
      #1;
      n_checks++; if (report_ready !== 1'b1) begin n_fail++; $display("FAIL timeout%0d_ready: got %b expected 1", pass, report_ready); end
      n_checks++; if (toggle !== 1'b1) begin n_fail++; $display("FAIL timeout%0d_toggle: got %b expected 1", pass, toggle); end
      n_checks++; if (sent !== 1'b0) begin n_fail++; $display("FAIL timeout%0d_sent: got %b expected 0", pass, sent); end
      if (pass == 0) load_report(r);
    end
  endtask

  task automatic test_reset_mid_data;
    send_pkt(make_tok(7'd5, 4'd1, 1'b0), 3, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_tx_valid: got %b expected 1", tx_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (toggle !== 1'b0) begin n_fail++; $display("FAIL rst_mid_toggle: got %b expected 0", toggle); end
    reset = 1'b0;
    send_pkt(make_tok(7'd5, 4'd1, 1'b0), 3, 1'b0);
    capture(99, 300);
    n_checks++; if (cap_n !== 1) begin n_fail++; $display("FAIL rst_nak_len: got %0d expected 1", cap_n); end
    n_checks++; if (cap_buf[0] !== 8'h5A) begin n_fail++; $display("FAIL rst_nak_pid: got %h expected 5a", cap_buf[0]); end
  endtask

  task automatic test_reject;
    logic [31:0] pk [0:4];
    int          nb [0:4];
    logic        er [0:4];
    int          exp_n;
    pk[0] = make_tok(7'd6, 4'd1, 1'b0); nb[0] = 3; er[0] = 1'b0;
    pk[1] = make_tok(7'd5, 4'd2, 1'b0); nb[1] = 3; er[1] = 1'b0;
    pk[2] = make_tok(7'd5, 4'd1, 1'b0); nb[2] = 4; er[2] = 1'b0;
    pk[3] = make_tok(7'd5, 4'd1, 1'b0); nb[3] = 3; er[3] = 1'b1;
    pk[4] = {make_tok(7'd5, 4'd1, 1'b0)} ^ 32'h0000_0088; nb[4] = 3; er[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_pkt(pk[k], nb[k], er[k]);
      capture(99, 20);
      n_checks++; if (cap_n !== 0) begin n_fail++; $display("FAIL reject%0d: got %0d bytes expected 0", k, cap_n); end
    end
`ifdef USB_LS_HID_CRC5_CHECK_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    send_pkt(make_tok(7'd5, 4'd1, 1'b1), 3, 1'b0);
    capture(99, 20);
    n_checks++; if (cap_n !== exp_n) begin n_fail++; $display("FAIL bad_crc5_len: got %0d expected %0d", cap_n, exp_n); end
`ifndef USB_LS_HID_CRC5_CHECK_EN
    n_checks++; if (cap_buf[0] !== 8'h5A) begin n_fail++; $display("FAIL bad_crc5_pid: got %h expected 5a", cap_buf[0]); end
`endif
  endtask

  initial begin
    test_reset;
    test_nak;
    test_data_ack;
    test_timeout_retry;
    test_reset_mid_data;
    test_reject;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
